// File: rtl/bcd_display_scanner_if.sv
// Bus between a BCD value source and the multiplexed seven-segment scanner.
// The master supplies digits and the enable. The slave drives the active-low display lines.
interface bcd_display_scanner_if #(
    parameter int N_DIGITS = 2
);
    logic [N_DIGITS*4-1:0] bcd_in;
    logic                  bcd_valid;
    logic                  display_enable;
    logic [6:0]            segments;
    logic [N_DIGITS-1:0]   digit_enable;

    modport master (
        output bcd_in, bcd_valid, display_enable,
        input  segments, digit_enable
    );

    modport slave (
        input  bcd_in, bcd_valid, display_enable,
        output segments, digit_enable
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed scanner for an N-digit common-anode seven-segment display.
// It has optional leading-zero blanking and an all-off gap at the end of each slot.
module bcd_display_scanner #(
    parameter int N_DIGITS            = 2,
    parameter int REFRESH_COUNT       = 50000,
    parameter int GAP_COUNT           = 500,
    parameter int BLANK_LEADING_ZEROS = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    bcd_display_scanner_if.slave   bus
);

    localparam int CNT_W = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(REFRESH_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ON_LAST = CNT_W'(REFRESH_COUNT - GAP_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN_ON  = 2'd1,
        SCAN_GAP = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d, cnt_inc;
    logic [IDX_W-1:0]      idx, idx_d;
    logic [N_DIGITS*4-1:0] buffer;
    logic [N_DIGITS-1:0]   blank;
    logic [6:0]            seg_d;
    logic [N_DIGITS-1:0]   den_d;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
        end
    end

    // NOTE: the buffer is reset as well, so a value latched before reset can never reappear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buffer <= '0;
        end else if (bus.bcd_valid) begin
            buffer <= bus.bcd_in;
        end
    end

    assign cnt_inc = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

    // NOTE: every combinational output gets a default first, which prevents latch inference.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        case (state)
            IDLE: begin
                if (bus.bcd_valid) begin
                    state_d = SCAN_ON;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            SCAN_ON: begin
                cnt_d = cnt_inc;
                if (cnt == CNT_ON_LAST) state_d = SCAN_GAP;
            end
            SCAN_GAP: begin
                cnt_d = cnt_inc;
                if (cnt == CNT_LAST) begin
                    state_d = SCAN_ON;
                    idx_d   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A nibble is a leading zero when it and every nibble above it are zero; nibble 0 never is.
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (buffer[i*4 +: 4] == 4'd0);
            blank[i]   = (BLANK_LEADING_ZEROS != 0) && zero_above;
        end
    end

    always_comb begin
        seg_d = 7'h7F;
        den_d = '1;
        if (state == SCAN_ON && bus.display_enable) begin
            den_d[idx] = 1'b0;
            seg_d      = blank[idx] ? 7'h7F : decode(buffer[idx*4 +: 4]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.segments     <= 7'h7F;
            bus.digit_enable <= '1;
        end else begin
            bus.segments     <= seg_d;
            bus.digit_enable <= den_d;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised scoreboard bench for bcd_display_scanner. A cycle-count reference model queues
// the expected display per edge, and a negedge monitor compares the queued values against the outputs.
module tb_bcd_display_scanner;

    localparam int N   = 2;
    localparam int RC  = 8;
    localparam int GC  = 2;
    localparam int BLZ = 1;

    localparam logic [6:0] DEC [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        logic [6:0]   seg;
        logic [N-1:0] den;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    bcd_display_scanner_if #(.N_DIGITS(N)) bus ();

    bcd_display_scanner #(
        .N_DIGITS           (N),
        .REFRESH_COUNT      (RC),
        .GAP_COUNT          (GC),
        .BLANK_LEADING_ZEROS(BLZ)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: cycles elapsed since the first capture determine slot, phase and digit.
    bit             started = 1'b0;
    int             p       = 0;
    logic [4*N-1:0] shown   = '0;
    exp_t           q [$];

    function automatic exp_t expect_out(input bit de);
        exp_t e;
        int   slot_idx;
        int   upper;
        int   nib;
        e.seg = 7'h7F;
        e.den = '1;
        if (started && de && (p % RC) < (RC - GC)) begin
            slot_idx        = (p / RC) % N;
            upper           = int'(shown) >> (4 * slot_idx);
            nib             = upper & 15;
            e.den[slot_idx] = 1'b0;
            if (BLZ != 0 && slot_idx > 0 && upper == 0) e.seg = 7'h7F;
            else if (nib < 10)                           e.seg = DEC[nib];
            else                                         e.seg = 7'h3F;
        end
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                started = 1'b0;
                p       = 0;
                shown   = '0;
                q.delete();
            end else begin
                q.push_back(expect_out(bus.display_enable));
                if (started) p++;
                if (bus.bcd_valid) begin
                    shown = bus.bcd_in;
                    if (!started) begin
                        started = 1'b1;
                        p       = 0;
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && q.size() > 0) begin
                e = q.pop_front();
                check("segments", 16'(bus.segments), 16'(e.seg));
                check("digit_enable", 16'(bus.digit_enable), 16'(e.den));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [4*N-1:0] v);
        @(negedge clock);
        bus.bcd_in    = v;
        bus.bcd_valid = 1'b1;
        @(negedge clock);
        bus.bcd_valid = 1'b0;
    endtask

    initial begin
        int k;
        bus.bcd_in         = '0;
        bus.bcd_valid      = 1'b0;
        bus.display_enable = 1'b1;

        idle(3);
        check("reset_segments", 16'(bus.segments), 16'h007F);
        check("reset_digit_enable", 16'(bus.digit_enable), 16'h0003);
        reset_n = 1'b1;
        idle(100);

        send(8'h15); idle(40);
        send(8'h07); idle(24);
        send(8'h00); idle(24);
        send(8'hA3); idle(24);

        idle(3);
        bus.display_enable = 1'b0;
        idle(5);
        bus.display_enable = 1'b1;
        idle(20);

        // Back-to-back captures guarantee some land on a slot boundary.
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            bus.bcd_in    = 8'($urandom);
            bus.bcd_valid = 1'b1;
        end
        @(negedge clock);
        bus.bcd_valid = 1'b0;
        idle(10);

        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            bus.bcd_valid      = ($urandom_range(0, 7) == 0);
            bus.bcd_in         = 8'($urandom);
            bus.display_enable = ($urandom_range(0, 9) != 0);
        end
        @(negedge clock);
        bus.bcd_valid      = 1'b0;
        bus.display_enable = 1'b1;

        send(8'h42);
        k = 0;
        while (bus.digit_enable !== 2'b01 && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("digit1_reached", 16'(k < 50), 16'h0001);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_segments", 16'(bus.segments), 16'h007F);
        check("async_reset_digit_enable", 16'(bus.digit_enable), 16'h0003);
        idle(3);
        reset_n = 1'b1;
        idle(30);

        send(8'h30); idle(20);
        send(8'h09); idle(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter N_DIGITS, default 2: number of BCD digits and display positions (1..8).
REQ-002 SHALL have parameter REFRESH_COUNT, default 50000: clock cycles per digit slot (>= GAP_COUNT+2).
REQ-003 SHALL have parameter GAP_COUNT, default 500: anti-ghost cycles at the end of each slot with all digits off (>= 1).
REQ-004 SHALL have parameter BLANK_LEADING_ZEROS, default 1: 1 blanks leading zeros, 0 shows every digit.
REQ-005 SHALL have port clock, input, 1 bit: single rising-edge clock for all logic.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port bcd_in, input, N_DIGITS*4 bits: packed BCD, nibble 0 (bits 3:0) least significant.
REQ-008 SHALL have port bcd_valid, input, 1 bit: one-cycle pulse; bcd_in is valid in the same cycle.
REQ-009 SHALL have port display_enable, input, 1 bit: 0 forces all digits off without losing the latched value.
REQ-010 SHALL have port segments, output, 7 bits: active-low, bit0=a through bit6=g.
REQ-011 SHALL have port digit_enable, output, N_DIGITS bits: active-low, at most one bit low at a time.

Function
REQ-012 SHALL capture bcd_in into an internal display buffer on every clock edge where bcd_valid=1; there is no other path into the buffer.
REQ-013 SHALL implement the state machine IDLE -> SCAN_ON -> SCAN_GAP -> SCAN_ON ..., where IDLE means no value has been latched since reset.
REQ-014 SHALL move IDLE -> SCAN_ON on the first bcd_valid, with digit index 0 and refresh counter 0.
REQ-015 SHALL advance the refresh counter by 1 per cycle in SCAN_ON/SCAN_GAP, wrapping REFRESH_COUNT-1 -> 0.
REQ-016 SHALL move SCAN_ON -> SCAN_GAP when the counter reaches REFRESH_COUNT-GAP_COUNT.
REQ-017 SHALL move SCAN_GAP -> SCAN_ON on counter wrap and advance the digit index, wrapping N_DIGITS-1 -> 0.
REQ-018 SHALL ignore bcd_valid during scanning except for the buffer update; the scan phase and index do not restart.
REQ-019 SHALL register segments and digit_enable, so that the outputs at cycle t+1 reflect the state, index and buffer at cycle t.
REQ-020 SHALL drive, in SCAN_ON with display_enable=1, digit_enable bit[index]=0, all other bits 1, and segments = the decode of nibble[index].
REQ-021 SHALL drive, in IDLE, in SCAN_GAP, or with display_enable=0, digit_enable = all 1s and segments = 7'h7F.
REQ-022 SHALL decode active-low as follows: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-023 SHALL decode nibble values 10..15 as dash 7'h3F (only g lit).
REQ-024 SHALL, when BLANK_LEADING_ZEROS=1, output 7'h7F for any nibble that is zero and has only zero nibbles above it, while keeping its digit enabled.
REQ-025 SHALL never blank nibble 0 under the leading-zero rule.
REQ-026 SHALL, on a bcd_valid that coincides with a slot boundary, apply the counter wrap and buffer update on the same edge; the new slot shows the new value.

Reset
REQ-027 SHALL, while reset_n=0 (asynchronous), force state=IDLE, index=0, refresh counter=0, buffer=0, segments=7'h7F, digit_enable = all 1s.
REQ-028 SHALL, when reset_n is asserted mid-scan, turn all digits off immediately without waiting for a clock edge.
REQ-029 SHALL, after reset_n is released, stay in IDLE until a new bcd_valid arrives; the previously latched value is discarded.

Verification (N_DIGITS=2, REFRESH_COUNT=8, GAP_COUNT=2, BLANK_LEADING_ZEROS=1)
REQ-030 SHALL cover: reset released with no bcd_valid for 100 cycles -> segments=7F and digit_enable=11 throughout.
REQ-031 SHALL cover: bcd_valid with bcd_in=8'h15 -> digit_enable=10 with segments=12 for 6 cycles, then 11 with 7F for 2 cycles, then 01 with 79 for 6 cycles, repeating.
REQ-032 SHALL cover: bcd_in=8'h07 -> digit 0 shows 78 and digit 1 is enabled (01) with segments=7F; bcd_in=8'h00 -> digit 0 shows 40.
REQ-033 SHALL cover: bcd_in=8'hA3 -> digit 1 shows 3F and digit 0 shows 30.
REQ-034 SHALL cover: display_enable=0 mid-slot -> digit_enable=11 on the next cycle; after re-enable, the scan resumes at its uninterrupted phase and index.
REQ-035 SHALL cover: reset_n pulsed low during SCAN_ON of digit 1 -> outputs go to 11/7F with no clock edge, and stay there after release until the next bcd_valid.
